// File: rtl/btb_table.sv
// Branch target buffer: combinational PC lookup, registered resolved-branch update.
// Optional 2-bit direction counters are enabled by defining BTB_COUNTER_EN.
module btb_table #(
  parameter int ADDR_WIDTH = 32,
  parameter int DEPTH      = 8,
  parameter int IDX_W      = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] lookup_pc,
  output logic                  pred_hit,
  output logic                  pred_taken,
  output logic [ADDR_WIDTH-1:0] pred_target,
  input  logic                  upd_valid,
  input  logic [ADDR_WIDTH-1:0] upd_pc,
  input  logic                  upd_taken,
  input  logic [ADDR_WIDTH-1:0] upd_target,
  input  logic                  flush,
  output logic [IDX_W:0]        occupancy
);

  logic [DEPTH-1:0]      valid_q, valid_d;
  logic [ADDR_WIDTH-1:0] key_q    [DEPTH];
  logic [ADDR_WIDTH-1:0] key_d    [DEPTH];
  logic [ADDR_WIDTH-1:0] target_q [DEPTH];
  logic [ADDR_WIDTH-1:0] target_d [DEPTH];
  logic [IDX_W-1:0]      rr_q, rr_d;
  logic [IDX_W:0]        occ_q, occ_d;

  logic                  look_hit_s;
  logic [IDX_W-1:0]      look_idx_s;
  logic                  upd_hit_s;
  logic [IDX_W-1:0]      upd_idx_s;
  logic                  free_s;
  logic [IDX_W-1:0]      free_idx_s;
  logic [IDX_W-1:0]      victim_s;

`ifdef BTB_COUNTER_EN
  logic [1:0] cnt_q [DEPTH];
  logic [1:0] cnt_d [DEPTH];

  function automatic logic [1:0] cnt_inc(input logic [1:0] c);
    return (c == 2'b11) ? 2'b11 : c + 2'b01;
  endfunction

  function automatic logic [1:0] cnt_dec(input logic [1:0] c);
    return (c == 2'b00) ? 2'b00 : c - 2'b01;
  endfunction
`endif

  // Priority searches: lowest index wins for lookup, update match and free slot.
  always_comb begin
    look_hit_s = 1'b0;
    look_idx_s = {IDX_W{1'b0}};
    upd_hit_s  = 1'b0;
    upd_idx_s  = {IDX_W{1'b0}};
    free_s     = 1'b0;
    free_idx_s = {IDX_W{1'b0}};
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (valid_q[i] && (key_q[i] == lookup_pc)) begin
        look_hit_s = 1'b1;
        look_idx_s = IDX_W'(i);
      end else begin
        look_hit_s = look_hit_s;
      end
      if (valid_q[i] && (key_q[i] == upd_pc)) begin
        upd_hit_s = 1'b1;
        upd_idx_s = IDX_W'(i);
      end else begin
        upd_hit_s = upd_hit_s;
      end
      if (!valid_q[i]) begin
        free_s     = 1'b1;
        free_idx_s = IDX_W'(i);
      end else begin
        free_s = free_s;
      end
    end
  end

  assign pred_hit    = look_hit_s;
  assign pred_target = look_hit_s ? target_q[look_idx_s] : {ADDR_WIDTH{1'b0}};
`ifdef BTB_COUNTER_EN
  assign pred_taken  = look_hit_s & cnt_q[look_idx_s][1];
`else
  assign pred_taken  = look_hit_s;
`endif
  assign occupancy   = occ_q;
  assign victim_s    = free_s ? free_idx_s : rr_q;

  // Next-state: flush beats update; fills take free slots, replacements advance rr.
  always_comb begin
    valid_d  = valid_q;
    key_d    = key_q;
    target_d = target_q;
    rr_d     = rr_q;
    occ_d    = occ_q;
`ifdef BTB_COUNTER_EN
    cnt_d    = cnt_q;
`endif
    if (flush) begin
      valid_d = {DEPTH{1'b0}};
      rr_d    = {IDX_W{1'b0}};
      occ_d   = {(IDX_W + 1){1'b0}};
    end else if (upd_valid) begin
      if (upd_hit_s) begin
        if (upd_taken) begin
          target_d[upd_idx_s] = upd_target;
`ifdef BTB_COUNTER_EN
          cnt_d[upd_idx_s]    = cnt_inc(cnt_q[upd_idx_s]);
`endif
        end else begin
`ifdef BTB_COUNTER_EN
          cnt_d[upd_idx_s]    = cnt_dec(cnt_q[upd_idx_s]);
`else
          target_d[upd_idx_s] = target_q[upd_idx_s];
`endif
        end
      end else if (upd_taken) begin
        valid_d[victim_s]  = 1'b1;
        key_d[victim_s]    = upd_pc;
        target_d[victim_s] = upd_target;
`ifdef BTB_COUNTER_EN
        cnt_d[victim_s]    = 2'b10;
`endif
        if (free_s) begin
          occ_d = occ_q + (IDX_W + 1)'(1'b1);
        end else begin
          rr_d  = rr_q + IDX_W'(1'b1);
        end
      end else begin
        valid_d = valid_q;
      end
    end else begin
      valid_d = valid_q;
    end
  end

  // Control state with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= {DEPTH{1'b0}};
      rr_q    <= {IDX_W{1'b0}};
      occ_q   <= {(IDX_W + 1){1'b0}};
    end else begin
      valid_q <= valid_d;
      rr_q    <= rr_d;
      occ_q   <= occ_d;
    end
  end

`ifdef BTB_COUNTER_EN
  // Direction counters reset to weakly not-taken.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        cnt_q[i] <= 2'b01;
      end
    end else begin
      cnt_q <= cnt_d;
    end
  end
`endif

  // Keys and targets are gated by valid, so they carry no reset.
  always_ff @(posedge clk) begin
    key_q    <= key_d;
    target_q <= target_d;
  end

endmodule

// File: tb/tb_btb_table.sv
// Directed self-checking bench for btb_table (DEPTH=8, ADDR_WIDTH=32).
module tb_btb_table;

  logic        clk;
  logic        reset;
  logic [31:0] lookup_pc;
  logic        pred_hit;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic        flush;
  logic [3:0]  occupancy;

  int checks;
  int failures;

  btb_table #(.ADDR_WIDTH(32), .DEPTH(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .lookup_pc   (lookup_pc),
    .pred_hit    (pred_hit),
    .pred_taken  (pred_taken),
    .pred_target (pred_target),
    .upd_valid   (upd_valid),
    .upd_pc      (upd_pc),
    .upd_taken   (upd_taken),
    .upd_target  (upd_target),
    .flush       (flush),
    .occupancy   (occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Lookup a PC between edges and compare hit/taken/target.
  task automatic look(input string tag, input logic [31:0] pc, input logic hit,
                      input logic taken, input logic [31:0] tgt);
    @(negedge clk);
    lookup_pc = pc;
    #1;
    check({tag, "_hit"}, {31'd0, pred_hit}, {31'd0, hit});
    check({tag, "_taken"}, {31'd0, pred_taken}, {31'd0, taken});
    check({tag, "_target"}, pred_target, tgt);
  endtask

  task automatic upd(input logic [31:0] pc, input logic taken, input logic [31:0] tgt);
    @(negedge clk);
    upd_valid  = 1'b1;
    upd_pc     = pc;
    upd_taken  = taken;
    upd_target = tgt;
    @(posedge clk);
    #1;
    upd_valid  = 1'b0;
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    reset      = 1'b1;
    lookup_pc  = 32'h0;
    upd_valid  = 1'b0;
    upd_pc     = 32'h0;
    upd_taken  = 1'b0;
    upd_target = 32'h0;
    flush      = 1'b0;

    @(negedge clk);
    #1;
    check("rst_hit", {31'd0, pred_hit}, 32'd0);
    check("rst_taken", {31'd0, pred_taken}, 32'd0);
    check("rst_target", pred_target, 32'h0);
    check("rst_occ", {28'd0, occupancy}, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    look("empty_key0", 32'h0, 1'b0, 1'b0, 32'h0);
    check("empty_occ", {28'd0, occupancy}, 32'd0);

    // Allocate with a same-cycle lookup that must still miss.
    @(negedge clk);
    upd_valid = 1'b1; upd_pc = 32'h100; upd_taken = 1'b1; upd_target = 32'h200;
    lookup_pc = 32'h100;
    #1;
    check("same_cycle_hit", {31'd0, pred_hit}, 32'd0);
    @(posedge clk);
    #1;
    upd_valid = 1'b0;
    look("alloc100", 32'h100, 1'b1, 1'b1, 32'h200);
    check("alloc_occ", {28'd0, occupancy}, 32'd1);

`ifdef BTB_COUNTER_EN
    upd(32'h100, 1'b0, 32'h0);
    look("nt1", 32'h100, 1'b1, 1'b0, 32'h200);
    upd(32'h100, 1'b0, 32'h0);
    look("nt2", 32'h100, 1'b1, 1'b0, 32'h200);
    upd(32'h100, 1'b1, 32'h200);
    upd(32'h100, 1'b1, 32'h200);
    upd(32'h100, 1'b1, 32'h200);
    look("t3", 32'h100, 1'b1, 1'b1, 32'h200);
    upd(32'h100, 1'b1, 32'h300);
    look("sat_t300", 32'h100, 1'b1, 1'b1, 32'h300);
    upd(32'h100, 1'b0, 32'h0);
    look("sat_nt", 32'h100, 1'b1, 1'b1, 32'h300);
`else
    upd(32'h100, 1'b0, 32'h999);
    look("nt_ignored", 32'h100, 1'b1, 1'b1, 32'h200);
    upd(32'h100, 1'b1, 32'h300);
    look("t300", 32'h100, 1'b1, 1'b1, 32'h300);
`endif
    check("hitupd_occ", {28'd0, occupancy}, 32'd1);

    // Flush overrides a simultaneous taken update.
    @(negedge clk);
    flush = 1'b1;
    upd_valid = 1'b1; upd_pc = 32'h500; upd_taken = 1'b1; upd_target = 32'h5A0;
    @(posedge clk);
    #1;
    flush = 1'b0;
    upd_valid = 1'b0;
    look("flush500", 32'h500, 1'b0, 1'b0, 32'h0);
    look("flush100", 32'h100, 1'b0, 1'b0, 32'h0);
    check("flush_occ", {28'd0, occupancy}, 32'd0);

    for (int i = 1; i <= 8; i++) begin
      upd(32'h10 * i, 1'b1, 32'h1000 + 32'h10 * i);
    end
    check("full_occ", {28'd0, occupancy}, 32'd8);
    look("full10", 32'h10, 1'b1, 1'b1, 32'h1010);
    look("full80", 32'h80, 1'b1, 1'b1, 32'h1080);

    upd(32'h400, 1'b0, 32'h4A0);
    look("nt_miss400", 32'h400, 1'b0, 1'b0, 32'h0);
    check("nt_miss_occ", {28'd0, occupancy}, 32'd8);

    upd(32'h90, 1'b1, 32'h1090);
    upd(32'hA0, 1'b1, 32'h10A0);
    look("repl10", 32'h10, 1'b0, 1'b0, 32'h0);
    look("repl20", 32'h20, 1'b0, 1'b0, 32'h0);
    look("keep30", 32'h30, 1'b1, 1'b1, 32'h1030);
    look("new90", 32'h90, 1'b1, 1'b1, 32'h1090);
    look("newA0", 32'hA0, 1'b1, 1'b1, 32'h10A0);
    check("repl_occ", {28'd0, occupancy}, 32'd8);
    upd(32'hB0, 1'b1, 32'h10B0);
    look("rr2_30", 32'h30, 1'b0, 1'b0, 32'h0);
    look("rr2_40", 32'h40, 1'b1, 1'b1, 32'h1040);

    // Reset lands on top of an in-flight update.
    @(negedge clk);
    upd_valid = 1'b1; upd_pc = 32'h700; upd_taken = 1'b1; upd_target = 32'h7A0;
    reset = 1'b1;
    #1;
    check("rst_async_occ", {28'd0, occupancy}, 32'd0);
    @(posedge clk);
    #1;
    upd_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    look("rst700", 32'h700, 1'b0, 1'b0, 32'h0);
    look("rst90", 32'h90, 1'b0, 1'b0, 32'h0);
    check("rst_mid_occ", {28'd0, occupancy}, 32'd0);

    for (int i = 0; i < 8; i++) begin
      upd(32'h800 + 32'h10 * i, 1'b1, 32'h2000 + 32'h10 * i);
    end
    check("refill_occ", {28'd0, occupancy}, 32'd8);
    look("refill800", 32'h800, 1'b1, 1'b1, 32'h2000);
    upd(32'h880, 1'b1, 32'h2080);
    look("entry0_800", 32'h800, 1'b0, 1'b0, 32'h0);
    look("entry1_810", 32'h810, 1'b1, 1'b1, 32'h2010);
    look("new880", 32'h880, 1'b1, 1'b1, 32'h2080);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
